imm_ext_unit: RTL and testbench

Parametrised immediate-extension stage for the processor datapath, generalising the fixed 8-to-16-bit zero extender. It takes an IN_W-bit immediate and produces an OUT_W-bit operand by zero-extension, sign-extension or high placement. It also supports a prefix mode that holds upper bits across instructions, so two instructions can build one full-width immediate. It sits between decode and the ALU B-operand mux, behind a one-entry registered output with valid/ready handshake.

---
 rtl/imm_ext_pkg.sv | 17 +
 rtl/imm_ext_core.sv | 37 +++
 rtl/imm_ext_unit.sv | 112 +++++++++++
 tb/tb_imm_ext_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension stage: operation codes and
// the prefix-tracking state encoding.
package imm_ext_pkg;

  // in_mode encodings
  localparam logic [1:0] MODE_ZE  = 2'd0;
  localparam logic [1:0] MODE_SE  = 2'd1;
  localparam logic [1:0] MODE_HI  = 2'd2;
  localparam logic [1:0] MODE_PFX = 2'd3;

  // Prefix tracking: IDLE has no held upper bits, PFX_HELD has a valid pfx
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_PFX_HELD = 1'b1
  } state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational extension datapath: builds the OUT_W-bit operand from the
// raw immediate, either by the mode's extension rule or by concatenating a
// held prefix above it.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]        data,
  input  logic [1:0]             mode,
  input  logic                   pfx_valid,
  input  logic [OUT_W-IN_W-1:0]  pfx,
  output logic [OUT_W-1:0]       result,
  output logic                   prefixed
);

  localparam int PW = OUT_W - IN_W;

  // A held prefix overrides the extension rule of ZE/SE/HI
  always_comb begin
    result   = '0;
    prefixed = 1'b0;
    if (pfx_valid) begin
      result   = {pfx, data};
      prefixed = 1'b1;
    end else begin
      unique case (mode)
        MODE_ZE: result = {{PW{1'b0}}, data};
        MODE_SE: result = {{PW{data[IN_W-1]}}, data};
        MODE_HI: result = {data, {PW{1'b0}}};
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/imm_ext_unit.sv
// Immediate-extension stage between decode and the ALU B-operand mux.
// Holds an optional prefix across instructions and presents each result
// through a one-entry registered output with valid/ready handshake.
module imm_ext_unit
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_prefixed
);

  localparam int PW = OUT_W - IN_W;

  if ((PW < 1) || (PW > IN_W)) begin : g_bad_width
    $error("imm_ext_unit: OUT_W - IN_W must lie in 1..IN_W");
  end

  state_e             state_q, state_d;
  logic [PW-1:0]      pfx_q, pfx_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_prefixed_q, out_prefixed_d;

  logic [OUT_W-1:0]   core_result;
  logic               core_prefixed;
  logic               accept;
  logic               is_pfx;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .data      (in_data),
    .mode      (in_mode),
    .pfx_valid (state_q == ST_PFX_HELD),
    .pfx       (pfx_q),
    .result    (core_result),
    .prefixed  (core_prefixed)
  );

  // Accept only when not flushing and the output slot is free or draining
  always_comb begin
    in_ready = !flush && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
    is_pfx   = (in_mode == MODE_PFX);
  end

  // Next-state: flush wins; otherwise drain, then load or capture a prefix
  always_comb begin
    state_d        = state_q;
    pfx_d          = pfx_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_prefixed_d = out_prefixed_q;
    if (flush) begin
      state_d        = ST_IDLE;
      out_valid_d    = 1'b0;
      out_prefixed_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        if (is_pfx) begin
          pfx_d   = in_data[PW-1:0];
          state_d = ST_PFX_HELD;
        end else begin
          out_valid_d    = 1'b1;
          out_data_d     = core_result;
          out_prefixed_d = core_prefixed;
          state_d        = ST_IDLE;
        end
      end
    end
  end

  // State, prefix and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      pfx_q          <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_prefixed_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pfx_q          <= pfx_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_prefixed_q <= out_prefixed_d;
    end
  end

  // Registered outputs
  always_comb begin
    out_valid    = out_valid_q;
    out_data     = out_data_q;
    out_prefixed = out_prefixed_q;
  end

endmodule

// File: tb/tb_imm_ext_unit.sv
// Directed bench for imm_ext_unit (IN_W=8, OUT_W=16). Expected results are
// queued when a beat is driven and checked when the consumer takes them.
module tb_imm_ext_unit;

  localparam logic [1:0] ZE  = 2'd0;
  localparam logic [1:0] SE  = 2'd1;
  localparam logic [1:0] HI  = 2'd2;
  localparam logic [1:0] PFX = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_prefixed;

  int checks = 0;
  int errors = 0;
  logic [16:0] sb[$];

  imm_ext_unit #(
    .IN_W  (8),
    .OUT_W (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_prefixed (out_prefixed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Consumer side: every handshake must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        logic [16:0] e;
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e[15:0]));
        chk("out_prefixed", 32'(out_prefixed), 32'(e[16]));
      end
    end
  end

  // Drive one cycle of inputs (starting just after a rising edge), check
  // in_ready mid-cycle, and return just after the next rising edge.
  task automatic step(input logic v, input logic [1:0] m, input logic [7:0] d,
                      input logic rdy, input logic fl, input logic exp_rdy,
                      input logic push, input logic [15:0] ed, input logic ep);
    in_valid  = v;
    in_mode   = m;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    if (push) sb.push_back({ep, ed});
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, ZE, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
  endtask

  // Assert reset mid-cycle, verify asynchronous clear, then release
  task automatic mid_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_prefixed", 32'(out_prefixed), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_mode = ZE; out_ready = 1'b1;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_prefixed", 32'(out_prefixed), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // ZE / SE / HI back-to-back, one cycle latency each
    step(1'b1, ZE, 8'h9C, 1'b1, 1'b0, 1'b1, 1'b1, 16'h009C, 1'b0);
    chk("lat_ze_valid", 32'(out_valid), 32'd1);
    chk("lat_ze_data", 32'(out_data), 32'h009C);
    step(1'b1, SE, 8'h9C, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFF9C, 1'b0);
    chk("lat_se_data", 32'(out_data), 32'hFF9C);
    step(1'b1, HI, 8'h9C, 1'b1, 1'b0, 1'b1, 1'b1, 16'h9C00, 1'b0);
    chk("lat_hi_data", 32'(out_data), 32'h9C00);
    idle();

    // Prefix then ZE builds a full immediate; following SE is unprefixed
    step(1'b1, PFX, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("pfx_no_output", 32'(out_valid), 32'd0);
    step(1'b1, ZE, 8'h34, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1);
    chk("pfx_ze_prefixed", 32'(out_prefixed), 32'd1);
    step(1'b1, SE, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFF80, 1'b0);
    idle();

    // Last prefix wins
    step(1'b1, PFX, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, PFX, 8'hAB, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("pfx2_no_output", 32'(out_valid), 32'd0);
    step(1'b1, SE, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 16'hAB01, 1'b1);
    idle();

    // Backpressure: output held for 5 cycles, then drain+load with no bubble
    step(1'b1, ZE, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, ZE, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'h0011);
    end
    step(1'b1, ZE, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0022, 1'b0);
    chk("no_bubble_valid", 32'(out_valid), 32'd1);
    chk("no_bubble_data", 32'(out_data), 32'h0022);
    idle();

    // Flush discards a pending prefixed result
    step(1'b1, PFX, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, ZE, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1266, 1'b1);
    chk("pend_prefixed", 32'(out_prefixed), 32'd1);
    step(1'b1, ZE, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_prefixed", 32'(out_prefixed), 32'd0);
    sb.delete();

    // Flush in PFX_HELD drops the beat and the prefix
    step(1'b1, PFX, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, ZE, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("flush_drop_valid", 32'(out_valid), 32'd0);
    step(1'b1, ZE, 8'h34, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0034, 1'b0);
    chk("post_flush_data", 32'(out_data), 32'h0034);
    chk("post_flush_prefixed", 32'(out_prefixed), 32'd0);
    idle();

    // Reset with a pending result, then reset while a prefix is held
    step(1'b1, ZE, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 16'h005A, 1'b0);
    mid_reset();
    step(1'b1, PFX, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    mid_reset();
    step(1'b1, ZE, 8'h34, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0034, 1'b0);
    chk("post_reset_data", 32'(out_data), 32'h0034);
    chk("post_reset_prefixed", 32'(out_prefixed), 32'd0);
    idle();
    idle();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
